// File: rtl/operand_seq_pkg.sv
// Shared state encoding and default widths for the operand sequencer.
package operand_seq_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 4;

  localparam int unsigned STATE_WIDTH = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

endpackage : operand_seq_pkg

// File: rtl/seq_counter.sv
// Entry pointer for the operand sequencer: clear, increment and ptr==last compare.
module seq_counter
  import operand_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] ptr,
  output logic             is_last_c
);

  // Pointer register; clear wins over increment so a job never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + WIDTH'(1);
    end
  end

  // Terminal compare against the latched job length.
  assign is_last_c = (ptr == last);

endmodule : seq_counter

// File: rtl/operand_sequencer.sv
// Loads depth+1 operand pairs into memories A/B, then issues each entry to the ALU.
module operand_sequencer
  import operand_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] depth,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] load_a,
  input  logic [DATA_WIDTH-1:0] load_b,
  output logic                  CS_0,
  output logic                  CS_1,
  output logic                  wr_en_0,
  output logic                  wr_en_1,
  output logic [ADDR_WIDTH-1:0] addr_out_0,
  output logic [ADDR_WIDTH-1:0] addr_out_1,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic [ADDR_WIDTH-1:0] opcode_out,
  output logic                  busy,
  output logic                  done
);

  logic [STATE_WIDTH-1:0] state;
  logic [STATE_WIDTH-1:0] state_nxt;
  logic [ADDR_WIDTH-1:0]  last;
  logic [ADDR_WIDTH-1:0]  ptr;
  logic                   is_last_c;
  logic                   ctr_clear;
  logic                   ctr_inc;
  logic                   last_load;

  logic                   cs_nxt;
  logic                   wr_nxt;
  logic [ADDR_WIDTH-1:0]  addr_nxt;
  logic [DATA_WIDTH-1:0]  a_nxt;
  logic [DATA_WIDTH-1:0]  b_nxt;
  logic [ADDR_WIDTH-1:0]  op_nxt;
  logic                   ready_nxt;
  logic                   busy_nxt;
  logic                   done_nxt;

  seq_counter #(
    .WIDTH(ADDR_WIDTH)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (ctr_clear),
    .inc      (ctr_inc),
    .last     (last),
    .ptr      (ptr),
    .is_last_c(is_last_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Job length is captured only when a job is accepted from IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= '0;
    end else if (last_load) begin
      last <= depth;
    end
  end

  // Next state, counter control and next registered output values.
  always_comb begin
    state_nxt = state;
    ctr_clear = 1'b0;
    ctr_inc   = 1'b0;
    last_load = 1'b0;
    cs_nxt    = 1'b0;
    wr_nxt    = 1'b0;
    addr_nxt  = '0;
    a_nxt     = '0;
    b_nxt     = '0;
    op_nxt    = '0;
    done_nxt  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          state_nxt = ST_LOAD;
          ctr_clear = 1'b1;
          last_load = 1'b1;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_nxt = ST_IDLE;
          ctr_clear = 1'b1;
        end else if (load_valid) begin
          cs_nxt   = 1'b1;
          wr_nxt   = 1'b1;
          addr_nxt = ptr;
          a_nxt    = load_a;
          b_nxt    = load_b;
          if (is_last_c) begin
            state_nxt = ST_EXEC;
            ctr_clear = 1'b1;
          end else begin
            ctr_inc = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        if (abort) begin
          state_nxt = ST_IDLE;
          ctr_clear = 1'b1;
        end else begin
          cs_nxt   = 1'b1;
          addr_nxt = ptr;
          op_nxt   = ptr;
          if (is_last_c) begin
            state_nxt = ST_FIN;
            ctr_clear = 1'b1;
          end else begin
            ctr_inc = 1'b1;
          end
        end
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
        ctr_clear = 1'b1;
        done_nxt  = !abort;
      end
      default: begin
        state_nxt = ST_IDLE;
        ctr_clear = 1'b1;
      end
    endcase

    ready_nxt = (state_nxt == ST_LOAD);
    busy_nxt  = (state_nxt != ST_IDLE);
  end

  // Output registers; both memories share select, address and write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      CS_0       <= 1'b0;
      CS_1       <= 1'b0;
      wr_en_0    <= 1'b0;
      wr_en_1    <= 1'b0;
      addr_out_0 <= '0;
      addr_out_1 <= '0;
      a_out      <= '0;
      b_out      <= '0;
      opcode_out <= '0;
      load_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      CS_0       <= cs_nxt;
      CS_1       <= cs_nxt;
      wr_en_0    <= wr_nxt;
      wr_en_1    <= wr_nxt;
      addr_out_0 <= addr_nxt;
      addr_out_1 <= addr_nxt;
      a_out      <= a_nxt;
      b_out      <= b_nxt;
      opcode_out <= op_nxt;
      load_ready <= ready_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

endmodule : operand_sequencer
